// File: rtl/div_iter_if.sv
// Handshake bundle between the E-stage issue logic and the iterative divider.
// Master drives the operation; slave (the divider) returns stall/ready/result.
interface div_iter_if #(
  parameter int WIDTH = 32
);
  logic               start_i;
  logic               signed_i;
  logic [WIDTH-1:0]   opa_i;
  logic [WIDTH-1:0]   opb_i;
  logic               annul_i;
  logic               hold_i;
  logic               stall_o;
  logic               ready_o;
  logic [2*WIDTH-1:0] result_o;

  modport master (
    output start_i, signed_i, opa_i, opb_i,
    output annul_i, hold_i,
    input  stall_o, ready_o, result_o
  );

  modport slave (
    input  start_i, signed_i, opa_i, opb_i,
    input  annul_i, hold_i,
    output stall_o, ready_o, result_o
  );
endinterface

// File: rtl/div_iter.sv
// Radix-2 restoring divider for DIV/DIVU, result {HI=rem, LO=quo}.
// Optional macro DIV_EARLY_OUT_EN: skip iterations when |a| < |b|.
module div_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic      clk,
  input  logic      rst,
  div_iter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIVZERO,
    S_ON,
    S_END
  } state_t;

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [WIDTH-1:0]     r_rem;
  logic [WIDTH-1:0]     r_quo;
  logic [WIDTH-1:0]     r_div;
  logic                 r_sa;
  logic                 r_sb;
  logic                 r_ready;
  logic [2*WIDTH-1:0]   r_result;

  logic                 w_neg_a;
  logic                 w_neg_b;
  logic [WIDTH-1:0]     w_mag_a;
  logic [WIDTH-1:0]     w_mag_b;
  logic                 w_bzero;
  logic [WIDTH:0]       w_shift;
  logic [WIDTH:0]       w_diff;
  logic                 w_qbit;
  logic [WIDTH-1:0]     w_rem_nx;
  logic [WIDTH-1:0]     w_quo_nx;
  logic [WIDTH-1:0]     w_rem_fix;
  logic [WIDTH-1:0]     w_quo_fix;
  logic                 w_last;

  assign w_neg_a = bus.signed_i & bus.opa_i[WIDTH-1];
  assign w_neg_b = bus.signed_i & bus.opb_i[WIDTH-1];
  assign w_mag_a = w_neg_a ? -bus.opa_i : bus.opa_i;
  assign w_mag_b = w_neg_b ? -bus.opb_i : bus.opb_i;
  assign w_bzero = (bus.opb_i == '0);

  // r_quo doubles as the dividend shift register
  assign w_shift  = {r_rem, r_quo[WIDTH-1]};
  assign w_diff   = w_shift - {1'b0, r_div};
  assign w_qbit   = ~w_diff[WIDTH];
  assign w_rem_nx = w_qbit ? w_diff[WIDTH-1:0]
                           : w_shift[WIDTH-1:0];
  assign w_quo_nx = {r_quo[WIDTH-2:0], w_qbit};

  assign w_quo_fix = (r_sa ^ r_sb) ? -w_quo_nx : w_quo_nx;
  assign w_rem_fix = r_sa ? -w_rem_nx : w_rem_nx;

  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

`ifdef DIV_EARLY_OUT_EN
  logic w_early;
  assign w_early = ~w_bzero & (w_mag_a < w_mag_b);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_ready  <= 1'b0;
      r_result <= '0;
    end else if (bus.annul_i) begin
      r_state <= S_IDLE;
      r_ready <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.start_i) begin
            r_rem <= '0;
            r_quo <= w_mag_a;
            r_div <= w_mag_b;
            r_sa  <= w_neg_a;
            r_sb  <= w_neg_b;
            r_cnt <= '0;
            if (w_bzero) begin
              r_state <= S_DIVZERO;
`ifdef DIV_EARLY_OUT_EN
            end else if (w_early) begin
              r_state  <= S_END;
              r_ready  <= 1'b1;
              r_result <= {bus.opa_i, {WIDTH{1'b0}}};
`endif
            end else begin
              r_state <= S_ON;
            end
          end
        end
        S_DIVZERO: begin
          r_result <= '0;
          r_ready  <= 1'b1;
          r_state  <= S_END;
        end
        S_ON: begin
          r_rem <= w_rem_nx;
          r_quo <= w_quo_nx;
          r_cnt <= r_cnt + 1'b1;
          // last iteration folds in the sign fix
          if (w_last) begin
            r_state  <= S_END;
            r_ready  <= 1'b1;
            r_result <= {w_rem_fix, w_quo_fix};
          end
        end
        S_END: begin
          if (!bus.hold_i) begin
            r_state <= S_IDLE;
            r_ready <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  // annul masks the stall so the flush can proceed
  assign bus.stall_o  = bus.start_i & ~r_ready & ~bus.annul_i;
  assign bus.ready_o  = r_ready;
  assign bus.result_o = r_result;

endmodule

// File: tb/tb_div_iter.sv
// Directed self-checking bench for div_iter (WIDTH=32).
// Inputs change 1ns after posedge; outputs sampled at negedge or posedge+1.
module tb_div_iter;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  div_iter_if #(.WIDTH(32)) bus ();

  div_iter #(
    .WIDTH(32),
    .CNT_W(6)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic drive_op(input logic sg,
                          input logic [31:0] a,
                          input logic [31:0] b);
    bus.signed_i = sg;
    bus.opa_i    = a;
    bus.opb_i    = b;
    bus.start_i  = 1'b1;
  endtask

  // Counts edges until ready, and cycles with stall high before it
  task automatic wait_ready(output int lat, output int stalls);
    lat    = 0;
    stalls = 0;
    while (lat < 100) begin
      @(negedge clk);
      if (bus.stall_o) stalls++;
      @(posedge clk);
      lat++;
      #1;
      if (bus.ready_o) break;
    end
  endtask

  task automatic release_op();
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    bus.start_i = 1'b0;
    bus.signed_i = 1'b0;
    bus.opa_i   = '0;
    bus.opb_i   = '0;
    bus.annul_i = 1'b0;
    bus.hold_i  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.ready_o !== 1'b0) begin
      failures++;
      $display("FAIL rst_ready got=%b exp=0", bus.ready_o);
    end
    checks++;
    if (bus.result_o !== 64'h0) begin
      failures++;
      $display("FAIL rst_result got=%h exp=0", bus.result_o);
    end
    checks++;
    if (bus.stall_o !== 1'b0) begin
      failures++;
      $display("FAIL rst_stall got=%b exp=0", bus.stall_o);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_divu();
    int lat, st;
    drive_op(1'b0, 32'd100, 32'd7);
    wait_ready(lat, st);
    checks++;
    if (lat !== 33) begin
      failures++;
      $display("FAIL divu_lat got=%0d exp=33", lat);
    end
    checks++;
    if (st !== 33) begin
      failures++;
      $display("FAIL divu_stall_cycles got=%0d exp=33", st);
    end
    checks++;
    if (bus.result_o !== {32'd2, 32'd14}) begin
      failures++;
      $display("FAIL divu_result got=%h exp=%h",
               bus.result_o, {32'd2, 32'd14});
    end
    checks++;
    if (bus.stall_o !== 1'b0) begin
      failures++;
      $display("FAIL divu_stall_end got=%b exp=0", bus.stall_o);
    end
    release_op();
  endtask

  task automatic test_signed();
    int lat, st;
    drive_op(1'b1, 32'hFFFF_FFF9, 32'd2);
    wait_ready(lat, st);
    checks++;
    if (bus.result_o !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
      failures++;
      $display("FAIL div_neg7_2 got=%h exp=ffffffff_fffffffd",
               bus.result_o);
    end
    checks++;
    if (lat !== 33) begin
      failures++;
      $display("FAIL div_neg7_2_lat got=%0d exp=33", lat);
    end
    release_op();
    drive_op(1'b1, 32'd7, 32'hFFFF_FFFE);
    wait_ready(lat, st);
    checks++;
    if (bus.result_o !== {32'h0000_0001, 32'hFFFF_FFFD}) begin
      failures++;
      $display("FAIL div_7_neg2 got=%h exp=00000001_fffffffd",
               bus.result_o);
    end
    release_op();
  endtask

  task automatic test_divzero();
    int lat, st;
    drive_op(1'b1, 32'hDEAD_BEEF, 32'h1);
    wait_ready(lat, st);
    release_op();
    drive_op(1'b0, 32'd5, 32'd0);
    wait_ready(lat, st);
    checks++;
    if (lat !== 2) begin
      failures++;
      $display("FAIL divzero_lat got=%0d exp=2", lat);
    end
    checks++;
    if (bus.result_o !== 64'h0) begin
      failures++;
      $display("FAIL divzero_result got=%h exp=0", bus.result_o);
    end
    release_op();
    drive_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_ready(lat, st);
    checks++;
    if (bus.result_o !== {32'h0, 32'h8000_0000}) begin
      failures++;
      $display("FAIL div_minint got=%h exp=00000000_80000000",
               bus.result_o);
    end
    release_op();
  endtask

  task automatic test_operand_capture();
    int lat, st;
    drive_op(1'b0, 32'hFFFF_FFFF, 32'h10);
    @(posedge clk);
    #1;
    bus.opa_i = 32'd1;
    bus.opb_i = 32'd0;
    wait_ready(lat, st);
    checks++;
    if (lat + 1 !== 33) begin
      failures++;
      $display("FAIL capture_lat got=%0d exp=33", lat + 1);
    end
    checks++;
    if (bus.result_o !== {32'hF, 32'h0FFF_FFFF}) begin
      failures++;
      $display("FAIL capture_result got=%h exp=0000000f_0fffffff",
               bus.result_o);
    end
    release_op();
  endtask

  task automatic test_annul();
    int lat, st;
    drive_op(1'b0, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    #1;
    bus.annul_i = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.stall_o !== 1'b0) begin
      failures++;
      $display("FAIL annul_stall got=%b exp=0", bus.stall_o);
    end
    @(posedge clk);
    #1;
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    checks++;
    if (bus.ready_o !== 1'b0) begin
      failures++;
      $display("FAIL annul_ready got=%b exp=0", bus.ready_o);
    end
    @(posedge clk);
    #1;
    drive_op(1'b0, 32'd1000, 32'd3);
    wait_ready(lat, st);
    checks++;
    if (lat !== 33) begin
      failures++;
      $display("FAIL annul_restart_lat got=%0d exp=33", lat);
    end
    checks++;
    if (bus.result_o !== {32'd1, 32'd333}) begin
      failures++;
      $display("FAIL annul_restart_result got=%h exp=%h",
               bus.result_o, {32'd1, 32'd333});
    end
    release_op();
  endtask

  task automatic test_hold_back_to_back();
    int lat, st;
    drive_op(1'b0, 32'd50, 32'd6);
    wait_ready(lat, st);
    bus.hold_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.ready_o !== 1'b1) begin
        failures++;
        $display("FAIL hold_ready[%0d] got=%b exp=1", i, bus.ready_o);
      end
      checks++;
      if (bus.result_o !== {32'd2, 32'd8}) begin
        failures++;
        $display("FAIL hold_result[%0d] got=%h exp=%h",
                 i, bus.result_o, {32'd2, 32'd8});
      end
    end
    bus.hold_i = 1'b0;
    bus.opa_i  = 32'd9;
    bus.opb_i  = 32'd4;
    @(posedge clk);
    #1;
    checks++;
    if (bus.ready_o !== 1'b0) begin
      failures++;
      $display("FAIL hold_release_ready got=%b exp=0", bus.ready_o);
    end
    checks++;
    if (bus.result_o !== {32'd2, 32'd8}) begin
      failures++;
      $display("FAIL hold_release_result got=%h exp=%h",
               bus.result_o, {32'd2, 32'd8});
    end
    wait_ready(lat, st);
    checks++;
    if (lat !== 33) begin
      failures++;
      $display("FAIL b2b_lat got=%0d exp=33", lat);
    end
    checks++;
    if (bus.result_o !== {32'd1, 32'd2}) begin
      failures++;
      $display("FAIL b2b_result got=%h exp=%h",
               bus.result_o, {32'd1, 32'd2});
    end
    release_op();
  endtask

  task automatic test_early_out();
    int lat, st;
    int exp_lat;
`ifdef DIV_EARLY_OUT_EN
    exp_lat = 1;
`else
    exp_lat = 33;
`endif
    drive_op(1'b0, 32'd3, 32'd10);
    wait_ready(lat, st);
    checks++;
    if (lat !== exp_lat) begin
      failures++;
      $display("FAIL early_lat got=%0d exp=%0d", lat, exp_lat);
    end
    checks++;
    if (bus.result_o !== {32'd3, 32'd0}) begin
      failures++;
      $display("FAIL early_result got=%h exp=%h",
               bus.result_o, {32'd3, 32'd0});
    end
    release_op();
  endtask

  task automatic test_reset_midop();
    int lat, st;
    drive_op(1'b0, 32'd100, 32'd7);
    repeat (5) @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0) begin
      failures++;
      $display("FAIL midop_rst got=%b/%h exp=0/0",
               bus.ready_o, bus.result_o);
    end
    drive_op(1'b0, 32'd100, 32'd7);
    wait_ready(lat, st);
    checks++;
    if (lat !== 33 || bus.result_o !== {32'd2, 32'd14}) begin
      failures++;
      $display("FAIL midop_restart got=%0d/%h exp=33/%h",
               lat, bus.result_o, {32'd2, 32'd14});
    end
    release_op();
  endtask

  initial begin
    test_reset();
    test_divu();
    test_signed();
    test_divzero();
    test_operand_capture();
    test_annul();
    test_hold_back_to_back();
    test_early_out();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
